// File: rtl/sparse_px_decoder.sv
// Zero-run-length activation stream decoder: emits non-zero pixels as (row, col, value).
// Optional SPDEC_STATS_EN adds saturating pixel / zero-run statistics outputs.
module sparse_px_decoder #(
  parameter int ROW_W = 10,
  parameter int COL_W = 16,
  parameter int DAT_W = 16,
  parameter int RUN_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ROW_W-1:0] px_row,
  output logic [COL_W-1:0] px_col,
  output logic [DAT_W-1:0] px_val,
  output logic             px_vld,
  input  logic             px_rdy,
  output logic             busy,
  output logic             done,
  output logic             err
`ifdef SPDEC_STATS_EN
  ,
  output logic [COL_W:0]   stat_px,
  output logic [COL_W:0]   stat_zero
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [1:0] T_PIX = 2'b00;
  localparam logic [1:0] T_ROW = 2'b01;
  localparam logic [1:0] T_EOS = 2'b10;

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q;
  // One bit wider than a column so that stepping past the last column is
  // remembered and any following PIX overflows instead of wrapping to col 0.
  logic [COL_W:0]   col_q;

  logic [1:0]       typ;
  logic [RUN_W-1:0] zrun;
  logic [COL_W:0]   sum;
  logic             accept;
  logic             start_ok;

  assign typ      = in_data[31:30];
  assign zrun     = in_data[16 +: RUN_W];
  assign sum      = col_q + (COL_W+1)'(zrun);
  assign accept   = in_valid && in_ready;
  assign start_ok = (state_q == IDLE) && start;

  assign in_ready = (state_q == RUN) && (!px_vld || px_rdy);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && typ == T_EOS) state_d = DRAIN;
      DRAIN:   if (!px_vld) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      px_row  <= '0;
      px_col  <= '0;
      px_val  <= '0;
      px_vld  <= 1'b0;
      err     <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      px_vld  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        row_q <= '0;
        col_q <= '0;
        err   <= 1'b0;
      end
      if (px_vld && px_rdy) px_vld <= 1'b0;
      if (accept) begin
        unique case (typ)
          T_PIX: begin
            if (sum[COL_W]) begin
              err <= 1'b1;
            end else begin
              px_row <= row_q;
              px_col <= sum[COL_W-1:0];
              px_val <= in_data[DAT_W-1:0];
              px_vld <= 1'b1;
              col_q  <= sum + (COL_W+1)'(1);
            end
          end
          T_ROW: begin
            row_q <= in_data[ROW_W-1:0];
            col_q <= '0;
          end
          T_EOS:   ;
          default: err <= 1'b1;
        endcase
      end
    end
  end

`ifdef SPDEC_STATS_EN
  logic [COL_W+1:0] zsum;
  assign zsum = {1'b0, stat_zero} + (COL_W+2)'(zrun);

  always_ff @(posedge clk) begin
    if (rst || flush || start_ok) begin
      stat_px   <= '0;
      stat_zero <= '0;
    end else begin
      if (px_vld && px_rdy && stat_px != '1) stat_px <= stat_px + 1'b1;
      if (accept && typ == T_PIX) stat_zero <= zsum[COL_W+1] ? '1 : zsum[COL_W:0];
    end
  end
`endif

endmodule

// File: tb/tb_sparse_px_decoder.sv
// Directed, table-driven self-checking bench for sparse_px_decoder.
module tb_sparse_px_decoder;

  logic        clk = 1'b0;
  logic        rst, start, flush, in_valid, px_rdy;
  logic [31:0] in_data;
  logic        in_ready, px_vld, busy, done, err;
  logic [9:0]  px_row;
  logic [15:0] px_col, px_val;
`ifdef SPDEC_STATS_EN
  logic [16:0] stat_px, stat_zero;
`endif

  always #5 clk = ~clk;

  sparse_px_decoder #(.ROW_W(10), .COL_W(16), .DAT_W(16), .RUN_W(14)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .px_row(px_row), .px_col(px_col), .px_val(px_val),
    .px_vld(px_vld), .px_rdy(px_rdy),
    .busy(busy), .done(done), .err(err)
`ifdef SPDEC_STATS_EN
    , .stat_px(stat_px), .stat_zero(stat_zero)
`endif
  );

  typedef struct {
    logic        st, fl, vin;
    logic [31:0] dat;
    logic        rdy, eir, evld;
    logic [31:0] erow, ecol, eval;
    logic        eerr, ebusy, edone;
  } vec_t;

  vec_t vec[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [31:0] EOS = 32'h8000_0000;
  localparam logic [31:0] RSV = 32'hC000_0000;

  function automatic logic [31:0] pix(input int z, input int v);
    return {2'b00, 14'(z), 16'(v)};
  endfunction

  function automatic logic [31:0] rowe(input int r);
    return {2'b01, 20'd0, 10'(r)};
  endfunction

  task automatic add(input logic st, fl, vin, input logic [31:0] dat, input logic rdy, eir, evld,
                     input int erow, ecol, eval, input logic eerr, ebusy, edone);
    vec_t v;
    v.st = st; v.fl = fl; v.vin = vin; v.dat = dat; v.rdy = rdy; v.eir = eir; v.evld = evld;
    v.erow = erow; v.ecol = ecol; v.eval = eval; v.eerr = eerr; v.ebusy = ebusy; v.edone = edone;
    vec.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    start = 0; flush = 0; in_valid = 0; in_data = '0;
  endtask

  initial begin
    rst = 1; px_rdy = 1; idle_in();
    tick(); tick();
    chk("rst_vld",   32'(px_vld), 0);
    chk("rst_ir",    32'(in_ready), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_err",   32'(err), 0);
    chk("rst_row",   32'(px_row), 0);
    chk("rst_col",   32'(px_col), 0);
    chk("rst_val",   32'(px_val), 0);
    rst = 0;
    tick();

    //  st fl vin dat                  rdy ir vld row col    val     err busy done
    // basic stream
    add(1, 0, 0, '0,                   1,  0, 0,  0, 0,     0,      0,  1,  0);
    add(0, 0, 1, rowe(5),              1,  1, 0,  0, 0,     0,      0,  1,  0);
    add(0, 0, 1, pix(0, 16'h1234),     1,  1, 1,  5, 0,     'h1234, 0,  1,  0);
    add(0, 0, 1, pix(3, 16'h00AA),     1,  1, 1,  5, 4,     'h00AA, 0,  1,  0);
    add(0, 0, 1, EOS,                  1,  1, 0,  0, 0,     0,      0,  1,  0);
    add(0, 0, 0, '0,                   1,  0, 0,  0, 0,     0,      0,  1,  1);
    add(0, 0, 0, '0,                   1,  0, 0,  0, 0,     0,      0,  0,  0);
    // backpressure: second PIX held off for 4 cycles
    add(1, 0, 0, '0,                   1,  0, 0,  0, 0,     0,      0,  1,  0);
    add(0, 0, 1, pix(1, 16'h0011),     0,  1, 1,  0, 1,     'h0011, 0,  1,  0);
    add(0, 0, 1, pix(2, 16'h0022),     0,  0, 1,  0, 1,     'h0011, 0,  1,  0);
    add(0, 0, 1, pix(2, 16'h0022),     0,  0, 1,  0, 1,     'h0011, 0,  1,  0);
    add(0, 0, 1, pix(2, 16'h0022),     0,  0, 1,  0, 1,     'h0011, 0,  1,  0);
    add(0, 0, 1, pix(2, 16'h0022),     0,  0, 1,  0, 1,     'h0011, 0,  1,  0);
    add(0, 0, 1, pix(2, 16'h0022),     1,  1, 1,  0, 4,     'h0022, 0,  1,  0);
    add(0, 0, 0, '0,                   1,  1, 0,  0, 0,     0,      0,  1,  0);
    add(0, 0, 1, EOS,                  1,  1, 0,  0, 0,     0,      0,  1,  0);
    add(0, 0, 0, '0,                   1,  0, 0,  0, 0,     0,      0,  1,  1);
    add(0, 0, 0, '0,                   1,  0, 0,  0, 0,     0,      0,  0,  0);
    // column range boundary and overflow
    add(1, 0, 0, '0,                   1,  0, 0,  0, 0,     0,      0,  1,  0);
    add(0, 0, 1, rowe(1),              1,  1, 0,  0, 0,     0,      0,  1,  0);
    add(0, 0, 1, pix(16383, 1),        1,  1, 1,  1, 16383, 1,      0,  1,  0);
    add(0, 0, 1, pix(16383, 2),        1,  1, 1,  1, 32767, 2,      0,  1,  0);
    add(0, 0, 1, pix(16383, 3),        1,  1, 1,  1, 49151, 3,      0,  1,  0);
    add(0, 0, 1, pix(16383, 4),        1,  1, 1,  1, 65535, 4,      0,  1,  0);
    add(0, 0, 1, pix(1, 5),            1,  1, 0,  0, 0,     0,      1,  1,  0);
    add(0, 0, 1, EOS,                  1,  1, 0,  0, 0,     0,      1,  1,  0);
    add(0, 0, 0, '0,                   1,  0, 0,  0, 0,     0,      1,  1,  1);
    add(0, 0, 0, '0,                   1,  0, 0,  0, 0,     0,      1,  0,  0);
    // reserved entry mid-stream
    add(1, 0, 0, '0,                   1,  0, 0,  0, 0,     0,      0,  1,  0);
    add(0, 0, 1, pix(2, 16'h0B0B),     1,  1, 1,  0, 2,     'h0B0B, 0,  1,  0);
    add(0, 0, 1, RSV,                  1,  1, 0,  0, 0,     0,      1,  1,  0);
    add(0, 0, 1, pix(1, 16'h0C0C),     1,  1, 1,  0, 4,     'h0C0C, 1,  1,  0);
    add(0, 0, 0, '0,                   0,  0, 1,  0, 4,     'h0C0C, 1,  1,  0);
    // flush with a pixel pending, then restart from row 0 / col 0
    add(0, 1, 0, '0,                   0,  0, 0,  0, 0,     0,      1,  0,  0);
    add(0, 0, 0, '0,                   1,  0, 0,  0, 0,     0,      1,  0,  0);
    add(1, 0, 0, '0,                   1,  0, 0,  0, 0,     0,      0,  1,  0);
    add(0, 0, 1, pix(0, 16'h0D0D),     1,  1, 1,  0, 0,     'h0D0D, 0,  1,  0);
    add(0, 0, 1, EOS,                  1,  1, 0,  0, 0,     0,      0,  1,  0);
    add(0, 0, 0, '0,                   1,  0, 0,  0, 0,     0,      0,  1,  1);
    add(0, 0, 0, '0,                   1,  0, 0,  0, 0,     0,      0,  0,  0);

    foreach (vec[i]) begin
      start = vec[i].st; flush = vec[i].fl; in_valid = vec[i].vin;
      in_data = vec[i].dat; px_rdy = vec[i].rdy;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vec[i].eir));
      tick();
      chk($sformatf("v%0d_px_vld", i), 32'(px_vld), 32'(vec[i].evld));
      if (vec[i].evld) begin
        chk($sformatf("v%0d_px_row", i), 32'(px_row), vec[i].erow);
        chk($sformatf("v%0d_px_col", i), 32'(px_col), vec[i].ecol);
        chk($sformatf("v%0d_px_val", i), 32'(px_val), vec[i].eval);
      end
      chk($sformatf("v%0d_err", i),  32'(err),  32'(vec[i].eerr));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vec[i].ebusy));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(vec[i].edone));
    end
    idle_in(); px_rdy = 1;
    tick();

`ifdef SPDEC_STATS_EN
    start = 1; tick(); start = 0;
    in_valid = 1;
    in_data = pix(2, 16'h0001); tick();
    in_data = pix(0, 16'h0002); tick();
    in_data = pix(5, 16'h0003); tick();
    in_valid = 0; tick();
    chk("stat_px", 32'(stat_px), 3);
    chk("stat_zero", 32'(stat_zero), 7);
    start = 0;
    flush = 1; tick(); flush = 0;
`endif

    // synchronous reset in the middle of a segment with err set and a pixel held
    start = 1; tick(); start = 0;
    in_valid = 1; in_data = RSV; tick();
    in_data = pix(1, 16'h0077); px_rdy = 0; tick();
    in_valid = 0;
    chk("mid_pre_vld", 32'(px_vld), 1);
    chk("mid_pre_err", 32'(err), 1);
    rst = 1; tick(); rst = 0;
    chk("mid_rst_vld",  32'(px_vld), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_err",  32'(err), 0);
    chk("mid_rst_col",  32'(px_col), 0);
    chk("mid_rst_val",  32'(px_val), 0);
    chk("mid_rst_ir",   32'(in_ready), 0);
`ifdef SPDEC_STATS_EN
    chk("mid_rst_stat_px", 32'(stat_px), 0);
    chk("mid_rst_stat_zero", 32'(stat_zero), 0);
`endif
    // after reset, a new segment starts at row 0 col 0
    px_rdy = 1;
    start = 1; tick(); start = 0;
    in_valid = 1; in_data = pix(0, 16'h0099); tick(); in_valid = 0;
    chk("post_rst_vld", 32'(px_vld), 1);
    chk("post_rst_col", 32'(px_col), 0);
    chk("post_rst_row", 32'(px_row), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
